// File: rtl/vme_xcvr_ctrl.sv
// VME transceiver control sequencer: break-before-make address/data buffer
// enables and a DTACK drive stage that rescinds high before releasing the line.

module vme_xcvr_chan #(
    parameter int g_TURN_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic dir,
    output logic rdy,
    output logic bus_dir,
    output logic bus_oe_n
);

    localparam int GAP_W = $clog2(g_TURN_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(g_TURN_CYCLES);

    typedef enum logic {
        CH_OFF,
        CH_ON
    } ch_state_t;

    ch_state_t        state, state_nxt;
    logic [GAP_W-1:0] gap, gap_nxt;
    logic             dir_nxt, oe_n_nxt, rdy_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= CH_OFF;
            gap      <= '0;
            bus_dir  <= 1'b0;
            bus_oe_n <= 1'b1;
            rdy      <= 1'b0;
        end else begin
            state    <= state_nxt;
            gap      <= gap_nxt;
            bus_dir  <= dir_nxt;
            bus_oe_n <= oe_n_nxt;
            rdy      <= rdy_nxt;
        end
    end

    // The direction pin only moves while the buffer is off, and every change
    // restarts the dead-time count before the buffer may be re-enabled.
    always_comb begin
        state_nxt = state;
        gap_nxt   = gap;
        dir_nxt   = bus_dir;
        oe_n_nxt  = bus_oe_n;
        rdy_nxt   = rdy;
        case (state)
            CH_OFF: begin
                oe_n_nxt = 1'b1;
                rdy_nxt  = 1'b0;
                if (dir != bus_dir) begin
                    dir_nxt = dir;
                    gap_nxt = '0;
                end else if (en && (gap == GAP_MAX)) begin
                    state_nxt = CH_ON;
                    oe_n_nxt  = 1'b0;
                end else if (gap != GAP_MAX) begin
                    gap_nxt = gap + GAP_W'(1);
                end
            end
            CH_ON: begin
                if (!en || (dir != bus_dir)) begin
                    state_nxt = CH_OFF;
                    oe_n_nxt  = 1'b1;
                    rdy_nxt   = 1'b0;
                    gap_nxt   = '0;
                end else begin
                    oe_n_nxt = 1'b0;
                    rdy_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = CH_OFF;
                oe_n_nxt  = 1'b1;
                rdy_nxt   = 1'b0;
                gap_nxt   = '0;
            end
        endcase
    end

endmodule

module vme_xcvr_ctrl #(
    parameter int g_TURN_CYCLES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic addr_en_i,
    input  logic addr_dir_i,
    output logic addr_rdy_o,
    output logic vme_addr_dir_o,
    output logic vme_addr_oe_n_o,
    input  logic data_en_i,
    input  logic data_dir_i,
    output logic data_rdy_o,
    output logic vme_data_dir_o,
    output logic vme_data_oe_n_o,
    input  logic dtack_req_i,
    output logic dtack_busy_o,
    output logic vme_dtack_oe_o,
    output logic vme_dtack_n_o
);

    localparam int CNT_W = $clog2(g_TURN_CYCLES + 1);
    localparam logic [CNT_W-1:0] RESC_MAX = CNT_W'(g_TURN_CYCLES);

    vme_xcvr_chan #(.g_TURN_CYCLES(g_TURN_CYCLES)) u_addr (
        .clk      (clk_i),
        .rst_n    (rst_n_i),
        .en       (addr_en_i),
        .dir      (addr_dir_i),
        .rdy      (addr_rdy_o),
        .bus_dir  (vme_addr_dir_o),
        .bus_oe_n (vme_addr_oe_n_o)
    );

    vme_xcvr_chan #(.g_TURN_CYCLES(g_TURN_CYCLES)) u_data (
        .clk      (clk_i),
        .rst_n    (rst_n_i),
        .en       (data_en_i),
        .dir      (data_dir_i),
        .rdy      (data_rdy_o),
        .bus_dir  (vme_data_dir_o),
        .bus_oe_n (vme_data_oe_n_o)
    );

    typedef enum logic [1:0] {
        D_IDLE,
        D_EN,
        D_LOW,
        D_RESC
    } dtack_state_t;

    dtack_state_t     dstate, dstate_nxt;
    logic [CNT_W-1:0] resc, resc_nxt;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            dstate         <= D_IDLE;
            resc           <= '0;
            vme_dtack_oe_o <= 1'b0;
            vme_dtack_n_o  <= 1'b1;
            dtack_busy_o   <= 1'b0;
        end else begin
            dstate         <= dstate_nxt;
            resc           <= resc_nxt;
            vme_dtack_oe_o <= (dstate_nxt != D_IDLE);
            vme_dtack_n_o  <= (dstate_nxt != D_LOW);
            dtack_busy_o   <= (dstate_nxt != D_IDLE);
        end
    end

    // A read must not be acknowledged before the data buffer is driving.
    always_comb begin
        dstate_nxt = dstate;
        resc_nxt   = resc;
        case (dstate)
            D_IDLE: begin
                if (dtack_req_i && (!data_en_i || data_rdy_o))
                    dstate_nxt = D_EN;
            end
            D_EN: begin
                if (dtack_req_i) begin
                    dstate_nxt = D_LOW;
                end else begin
                    dstate_nxt = D_RESC;
                    resc_nxt   = CNT_W'(1);
                end
            end
            D_LOW: begin
                if (!dtack_req_i) begin
                    dstate_nxt = D_RESC;
                    resc_nxt   = CNT_W'(1);
                end
            end
            D_RESC: begin
                if (resc == RESC_MAX)
                    dstate_nxt = D_IDLE;
                else
                    resc_nxt = resc + CNT_W'(1);
            end
            default: begin
                dstate_nxt = D_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_vme_xcvr_ctrl.sv
// Directed and randomized checks for the VME transceiver control sequencer.

module tb_vme_xcvr_ctrl;

    localparam int TURN = 2;

    logic clk_i = 1'b0;
    logic rst_n_i;
    logic addr_en_i, addr_dir_i, addr_rdy_o, vme_addr_dir_o, vme_addr_oe_n_o;
    logic data_en_i, data_dir_i, data_rdy_o, vme_data_dir_o, vme_data_oe_n_o;
    logic dtack_req_i, dtack_busy_o, vme_dtack_oe_o, vme_dtack_n_o;

    int checks = 0;
    int failures = 0;

    vme_xcvr_ctrl #(.g_TURN_CYCLES(TURN)) dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .addr_en_i       (addr_en_i),
        .addr_dir_i      (addr_dir_i),
        .addr_rdy_o      (addr_rdy_o),
        .vme_addr_dir_o  (vme_addr_dir_o),
        .vme_addr_oe_n_o (vme_addr_oe_n_o),
        .data_en_i       (data_en_i),
        .data_dir_i      (data_dir_i),
        .data_rdy_o      (data_rdy_o),
        .vme_data_dir_o  (vme_data_dir_o),
        .vme_data_oe_n_o (vme_data_oe_n_o),
        .dtack_req_i     (dtack_req_i),
        .dtack_busy_o    (dtack_busy_o),
        .vme_dtack_oe_o  (vme_dtack_oe_o),
        .vme_dtack_n_o   (vme_dtack_n_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_addr_oe_n"}, vme_addr_oe_n_o, 1);
        chk({tag, "_data_oe_n"}, vme_data_oe_n_o, 1);
        chk({tag, "_addr_dir"}, vme_addr_dir_o, 0);
        chk({tag, "_data_dir"}, vme_data_dir_o, 0);
        chk({tag, "_addr_rdy"}, addr_rdy_o, 0);
        chk({tag, "_data_rdy"}, data_rdy_o, 0);
        chk({tag, "_dtack_oe"}, vme_dtack_oe_o, 0);
        chk({tag, "_dtack_n"}, vme_dtack_n_o, 1);
        chk({tag, "_busy"}, dtack_busy_o, 0);
    endtask

    logic p_addr_oe_n, p_data_oe_n, p_addr_dir, p_data_dir, p_dtack_oe;
    int   addr_hi, data_hi, nhi;

    initial begin
        rst_n_i = 0; addr_en_i = 0; addr_dir_i = 0;
        data_en_i = 0; data_dir_i = 0; dtack_req_i = 0;
        tick(); tick();
        chk_reset_vals("reset");

        // First enable after reset release: oe_n low after edge 3, rdy after edge 4.
        rst_n_i = 1; addr_en_i = 1;
        tick(); chk("first_en_e1_oe_n", vme_addr_oe_n_o, 1);
        tick(); chk("first_en_e2_oe_n", vme_addr_oe_n_o, 1);
        tick(); chk("first_en_e3_oe_n", vme_addr_oe_n_o, 0);
        chk("first_en_e3_rdy", addr_rdy_o, 0);
        tick(); chk("first_en_e4_rdy", addr_rdy_o, 1);
        chk("first_en_dir", vme_addr_dir_o, 0);

        // Data channel: gap already saturated, so one-edge enable latency.
        data_en_i = 1;
        tick(); chk("data_en_oe_n", vme_data_oe_n_o, 0);
        chk("data_en_rdy0", data_rdy_o, 0);
        tick(); chk("data_en_rdy1", data_rdy_o, 1);

        // Direction turn while ON.
        data_dir_i = 1;
        tick(); chk("turn_k_oe_n", vme_data_oe_n_o, 1);
        chk("turn_k_dir", vme_data_dir_o, 0);
        chk("turn_k_rdy", data_rdy_o, 0);
        tick(); chk("turn_k1_oe_n", vme_data_oe_n_o, 1);
        chk("turn_k1_dir", vme_data_dir_o, 1);
        tick(); chk("turn_k2_oe_n", vme_data_oe_n_o, 1);
        tick(); chk("turn_k3_oe_n", vme_data_oe_n_o, 1);
        tick(); chk("turn_k4_oe_n", vme_data_oe_n_o, 0);
        chk("turn_k4_rdy", data_rdy_o, 0);
        tick(); chk("turn_k5_rdy", data_rdy_o, 1);

        // Disable address channel.
        addr_en_i = 0;
        tick(); chk("dis_addr_oe_n", vme_addr_oe_n_o, 1);
        chk("dis_addr_rdy", addr_rdy_o, 0);

        // Read: DTACK requested before the data buffer is ready.
        data_en_i = 0;
        tick(); chk("rd_data_off", vme_data_oe_n_o, 1);
        data_en_i = 1; dtack_req_i = 1;
        tick(); chk("rd_a0_oe", vme_dtack_oe_o, 0);
        tick(); chk("rd_a1_oe", vme_dtack_oe_o, 0);
        tick(); chk("rd_a2_oe", vme_dtack_oe_o, 0);
        chk("rd_a2_data_oe_n", vme_data_oe_n_o, 0);
        tick(); chk("rd_a3_rdy", data_rdy_o, 1);
        chk("rd_a3_oe", vme_dtack_oe_o, 0);
        tick(); chk("rd_a4_oe", vme_dtack_oe_o, 1);
        chk("rd_a4_n", vme_dtack_n_o, 1);
        chk("rd_a4_busy", dtack_busy_o, 1);
        tick(); chk("rd_a5_n", vme_dtack_n_o, 0);
        tick(); chk("rd_a6_n", vme_dtack_n_o, 0);
        dtack_req_i = 0;
        tick(); chk("rd_resc0_n", vme_dtack_n_o, 1);
        chk("rd_resc0_oe", vme_dtack_oe_o, 1);
        tick(); chk("rd_resc1_oe", vme_dtack_oe_o, 1);
        chk("rd_resc1_busy", dtack_busy_o, 1);
        tick(); chk("rd_idle_oe", vme_dtack_oe_o, 0);
        chk("rd_idle_busy", dtack_busy_o, 0);

        // One-cycle request pulse: DTACK never driven low.
        dtack_req_i = 1;
        tick(); chk("pulse_en_oe", vme_dtack_oe_o, 1);
        chk("pulse_en_n", vme_dtack_n_o, 1);
        dtack_req_i = 0;
        tick(); chk("pulse_r0_n", vme_dtack_n_o, 1);
        chk("pulse_r0_busy", dtack_busy_o, 1);
        tick(); chk("pulse_r1_n", vme_dtack_n_o, 1);
        chk("pulse_r1_oe", vme_dtack_oe_o, 1);
        tick(); chk("pulse_idle_oe", vme_dtack_oe_o, 0);
        chk("pulse_idle_n", vme_dtack_n_o, 1);

        // Reset while both channels ON and DTACK low.
        addr_en_i = 1; dtack_req_i = 1;
        tick(); chk("mid_addr_on", vme_addr_oe_n_o, 0);
        tick(); chk("mid_dtack_low", vme_dtack_n_o, 0);
        chk("mid_data_on", vme_data_oe_n_o, 0);
        rst_n_i = 0;
        tick(); chk_reset_vals("midrst");
        rst_n_i = 1; data_dir_i = 0; dtack_req_i = 0;
        tick(); chk("re_e1_addr", vme_addr_oe_n_o, 1); chk("re_e1_data", vme_data_oe_n_o, 1);
        tick(); chk("re_e2_addr", vme_addr_oe_n_o, 1); chk("re_e2_data", vme_data_oe_n_o, 1);
        tick(); chk("re_e3_addr", vme_addr_oe_n_o, 0); chk("re_e3_data", vme_data_oe_n_o, 0);
        tick(); chk("re_e4_addr_rdy", addr_rdy_o, 1); chk("re_e4_data_rdy", data_rdy_o, 1);

        // Randomized stimulus with per-cycle safety invariants.
        rst_n_i = 0; addr_en_i = 0; addr_dir_i = 0;
        data_en_i = 0; data_dir_i = 0; dtack_req_i = 0;
        tick();
        rst_n_i = 1;
        p_addr_oe_n = vme_addr_oe_n_o; p_data_oe_n = vme_data_oe_n_o;
        p_addr_dir = vme_addr_dir_o; p_data_dir = vme_data_dir_o;
        p_dtack_oe = vme_dtack_oe_o;
        addr_hi = 0; data_hi = 0; nhi = 0;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 7) == 0) addr_en_i = ~addr_en_i;
            if ($urandom_range(0, 15) == 0) addr_dir_i = ~addr_dir_i;
            if ($urandom_range(0, 7) == 0) data_en_i = ~data_en_i;
            if ($urandom_range(0, 15) == 0) data_dir_i = ~data_dir_i;
            if ($urandom_range(0, 5) == 0) dtack_req_i = ~dtack_req_i;
            tick();
            if (vme_addr_dir_o != p_addr_dir)
                chk("rnd_addr_dir_while_off", {p_addr_oe_n, vme_addr_oe_n_o}, 2'b11);
            if (vme_data_dir_o != p_data_dir)
                chk("rnd_data_dir_while_off", {p_data_oe_n, vme_data_oe_n_o}, 2'b11);
            if (p_addr_oe_n && !vme_addr_oe_n_o)
                chk("rnd_addr_gap", addr_hi >= TURN, 1);
            if (p_data_oe_n && !vme_data_oe_n_o)
                chk("rnd_data_gap", data_hi >= TURN, 1);
            if (p_dtack_oe && !vme_dtack_oe_o)
                chk("rnd_dtack_rescind", nhi >= TURN, 1);
            chk("rnd_n_low_needs_oe", !vme_dtack_n_o && !vme_dtack_oe_o, 0);
            addr_hi = vme_addr_oe_n_o ? addr_hi + 1 : 0;
            data_hi = vme_data_oe_n_o ? data_hi + 1 : 0;
            nhi = (vme_dtack_oe_o && vme_dtack_n_o) ? nhi + 1 : 0;
            p_addr_oe_n = vme_addr_oe_n_o; p_data_oe_n = vme_data_oe_n_o;
            p_addr_dir = vme_addr_dir_o; p_data_dir = vme_data_dir_o;
            p_dtack_oe = vme_dtack_oe_o;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vme_xcvr_ctrl.md
# vme_xcvr_ctrl

Sequencer for the SVEC VME transceiver controls: address/LWORD buffer, data buffer and the DTACK open-drive stage. Sits between the VME64x slave core and the board transceivers, directly upstream of the buffer stage; it drives that stage's ADDR_DIR/ADDR_OE_N, DATA_DIR/DATA_OE_N, DTACK_OE and DTACK_n inputs. It guarantees break-before-make on every direction change and a driven-high DTACK rescind before release, so the FPGA and the backplane never drive a transceiver side simultaneously.

## Interface
- g_TURN_CYCLES, 2: dead cycles with a buffer disabled before it may be re-enabled (after disable or direction change); also the DTACK rescind length. Legal range 1..15.

- clk_i  in  1  system clock; all logic on rising edge
- rst_n_i  in  1  synchronous, active-low reset
- addr_en_i  in  1  core wants the address buffer enabled (level)
- addr_dir_i  in  1  requested direction: 0 backplane->FPGA, 1 FPGA->backplane
- addr_rdy_o  out  1  address buffer enabled and stable in the requested direction
- vme_addr_dir_o  out  1  to transceiver ADDR_DIR
- vme_addr_oe_n_o  out  1  to transceiver ADDR_OE_N
- data_en_i, data_dir_i, data_rdy_o  in/in/out  1 each  same as the addr_* ports, data buffer
- vme_data_dir_o, vme_data_oe_n_o  out  1 each  to DATA_DIR, DATA_OE_N
- dtack_req_i  in  1  core requests DTACK asserted (level)
- dtack_busy_o  out  1  DTACK stage active, from enable through the end of the rescind
- vme_dtack_oe_o  out  1  to DTACK_OE
- vme_dtack_n_o  out  1  to DTACK_n

## Operation
- Two identical channel FSMs (addr, data); each has a gap counter, width clog2(g_TURN_CYCLES+1), saturating at g_TURN_CYCLES.
- Channel OFF: oe_n=1, rdy=0. Each cycle:
  - If dir_i != dir_o: dir_o <= dir_i, gap <= 0.
  - Else if en_i and gap == g_TURN_CYCLES: go ON, oe_n <= 0.
  - Else gap increments (saturating).
- Channel ON: oe_n=0. If en_i=0 or dir_i != dir_o: go OFF, oe_n <= 1, rdy <= 0, gap <= 0. Otherwise rdy <= 1.
- dir_o never changes while oe_n=0. dir_i is sampled only when en_i or a mismatch exists; a mismatch with en_i=0 still updates dir_o in OFF.
- The channels are independent; the core alone is responsible for cross-channel protocol ordering.
- DTACK FSM:
  - D_IDLE (oe=0, n=1): go to D_EN when dtack_req_i=1 and (data_en_i=0 or data_rdy_o=1).
  - D_EN (oe=1, n=1), one cycle: go to D_LOW if dtack_req_i=1, else D_RESC.
  - D_LOW (oe=1, n=0): stay while dtack_req_i=1, else go to D_RESC.
  - D_RESC (oe=1, n=1): stay g_TURN_CYCLES cycles, then go to D_IDLE. A request arriving during D_RESC waits for D_IDLE.
- dtack_busy_o=1 in every state except D_IDLE.

## Timing
- All outputs are registered.
- Reset values: vme_addr_oe_n_o=vme_data_oe_n_o=1, vme_addr_dir_o=vme_data_dir_o=0, addr_rdy_o=data_rdy_o=0, vme_dtack_oe_o=0, vme_dtack_n_o=1, dtack_busy_o=0. All gap counters=0; FSMs in OFF/D_IDLE.
- Reset asserted mid-operation forces every output to its reset value at the next edge; there is no graceful rescind.
- First enable after reset (dir match): oe_n falls after rising edge g_TURN_CYCLES+1 with rst_n_i high; rdy rises one edge later.
- Enable latency, with dir matched and gap saturated: en_i sampled high at edge k -> oe_n low after k -> rdy high after k+1.
- Disable: en_i sampled low at edge k -> oe_n high and rdy low after k.
- Direction turn while ON: oe_n high for g_TURN_CYCLES+2 cycles; dir_o changes one cycle after oe_n rises; rdy returns one cycle after oe_n falls.
- DTACK: vme_dtack_oe_o rises one cycle before vme_dtack_n_o falls. vme_dtack_n_o returns high at least g_TURN_CYCLES cycles before vme_dtack_oe_o falls.
- dtack_req_i dropped during D_EN: DTACK is never driven low.

## Test plan
- Reset release, addr_en_i=1, addr_dir_i=0, g_TURN_CYCLES=2 -> vme_addr_oe_n_o low after edge 3, addr_rdy_o high after edge 4; vme_addr_dir_o stays 0 throughout.
- Data channel ON with dir 0; at edge k set data_dir_i=1 -> oe_n high after k..k+3, dir_o=1 after k+1, oe_n low after k+4, data_rdy_o high after k+5; oe_n never low while dir_o toggles.
- Read: data_en_i=1, data_dir_i=1, dtack_req_i=1 raised before data_rdy_o -> vme_dtack_oe_o not asserted until data_rdy_o=1. Then oe rises, n falls one cycle later; drop req -> n high, oe held 2 cycles, busy low afterwards.
- dtack_req_i pulsed for one cycle -> D_EN then D_RESC; vme_dtack_n_o stays 1 for the whole sequence.
- rst_n_i asserted while both channels are ON and DTACK is low -> next edge all outputs at reset values; re-enable obeys the first-enable latency.
- Random en/dir/req stimulus for 10k cycles; checks at every cycle:
  - dir_o changes only when oe_n=1 and has been 1 for at least one cycle.
  - oe_n=1 holds for at least g_TURN_CYCLES cycles before each enable.
  - n=0 only while oe=1.
